// File: rtl/cpu_sequencer.sv
// cpu_sequencer: single-clock instruction sequencer.
// Steps one instruction at a time through fetch, decode, execute, memory and
// writeback, emitting one-cycle enables for the IR, PC, register file and
// memory. Memory reads either take a fixed number of wait states or wait for
// mem_ready, with a bus timeout. Illegal opcodes and bus timeouts park the
// sequencer in TRAP until reset. A retired-instruction counter counts every
// writeback.
module cpu_sequencer #(
    parameter int USE_READY = 0,   // 0: fixed MEM_WAIT latency, 1: mem_ready handshake
    parameter int MEM_WAIT  = 1,   // wait cycles per read when USE_READY=0 (1..15)
    parameter int TIMEOUT   = 15,  // cycles without mem_ready before trap (1..255)
    parameter int CNT_W     = 32   // instret width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_en,
    output logic             ra_sel,
    output logic             ir_en,
    output logic             mem_wen_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXECUTE    = 4'd4,
        S_MEM        = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WRITEBACK  = 4'd7,
        S_TRAP       = 4'd8
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    localparam bit         HANDSHAKE    = (USE_READY != 0);
    localparam logic [7:0] WAIT_LAST    = 8'(MEM_WAIT - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t             state_q;
    logic [7:0]         wait_cnt_q;
    logic [1:0]         trap_cause_q;
    logic [CNT_W-1:0]   instret_q;
    logic               step_q;

    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_legal;
    logic               step_rise;
    logic               wait_done;
    logic               wait_timeout;

    // Opcode classification from the instruction register.
    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        case (opcode)
            7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    end

    // Wait-state completion and timeout; a ready on the timeout cycle wins.
    always_comb begin
        step_rise    = step & ~step_q;
        wait_done    = HANDSHAKE ? mem_ready : (wait_cnt_q == WAIT_LAST);
        wait_timeout = HANDSHAKE && !mem_ready && (wait_cnt_q == TIMEOUT_LAST);
    end

    // Sequencer state, wait counter, trap cause, instret and step edge detect.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them sample the
        // pre-edge values; a blocking = would let later lines see new state.
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            trap_cause_q <= CAUSE_NONE;
            instret_q    <= '0;
            step_q       <= 1'b0;
        end else begin
            step_q <= step;
            case (state_q)
                S_IDLE: begin
                    if (run || step_rise) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    wait_cnt_q <= 8'd0;
                    state_q    <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                    if (wait_done) begin
                        state_q <= S_DECODE;
                    end else if (wait_timeout) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_BUS;
                    end
                end
                S_DECODE: begin
                    if (is_legal) begin
                        state_q <= S_EXECUTE;
                    end else begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_ILLEGAL;
                    end
                end
                S_EXECUTE: begin
                    state_q <= (is_load || is_store) ? S_MEM : S_WRITEBACK;
                end
                S_MEM: begin
                    // Stores are posted: the single MEM cycle carries the strobe.
                    wait_cnt_q <= 8'd0;
                    state_q    <= is_store ? S_WRITEBACK : S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                    if (wait_done) begin
                        state_q <= S_WRITEBACK;
                    end else if (wait_timeout) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= CAUSE_BUS;
                    end
                end
                S_WRITEBACK: begin
                    instret_q <= instret_q + CNT_W'(1);
                    state_q   <= run ? S_FETCH : S_IDLE;
                end
                S_TRAP: begin
                    // Parked until reset; run and step are ignored.
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore strobe decode from the current state; ir_en also needs wait_done.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through it leaves a signal unassigned, which would infer a latch.
        mem_en     = 1'b0;
        ra_sel     = 1'b0;
        ir_en      = 1'b0;
        mem_wen_en = 1'b0;
        wb_en      = 1'b0;
        pc_en      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_en = 1'b1;
            end
            S_FETCH_WAIT: begin
                mem_en = 1'b1;
                ir_en  = wait_done;
            end
            S_MEM: begin
                mem_en     = 1'b1;
                ra_sel     = 1'b1;
                mem_wen_en = is_store;
            end
            S_MEM_WAIT: begin
                mem_en = 1'b1;
                ra_sel = 1'b1;
            end
            S_WRITEBACK: begin
                wb_en = !(is_store || is_branch);
                pc_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state      = state_q;
    assign halted     = (state_q == S_IDLE) || (state_q == S_TRAP);
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

endmodule
